// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store controller.
//   - RV32I load/store funct3 encodings
//   - byte-lane size masks
//   - controller state encoding
//   - small decode helpers
// Build option: LSU_MISALIGN_EN (see lsu_ctrl.sv).
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // funct3[1:0] carries the access size for every legal encoding
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   return off[0];
      2'b10:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// lsu_align: purely combinational lane steering for lsu_ctrl.
//   i_f3, i_off      : funct3 and byte offset of the access
//   i_wdata          : right-aligned store data
//   i_lo, i_hi       : first / second word of a load
//   o_wea_lo/o_wea_hi: byte enables for the first / second word
//   o_din            : store data rotated onto its byte lanes
//   o_rdata          : extracted and extended load result
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [3:0]  o_wea_lo,
  output logic [3:0]  o_wea_hi,
  output logic [31:0] o_din,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask8;
  logic [63:0] w_rot;
  logic [63:0] w_sh;

  always_comb begin
    w_mask8  = {4'b0000, size_mask(i_f3[1:0])} << i_off;
    o_wea_lo = w_mask8[3:0];
    o_wea_hi = w_mask8[7:4];
    // rotate, so the same din serves both words of a split store
    w_rot    = {i_wdata, i_wdata} << {i_off, 3'b000};
    o_din    = w_rot[63:32];
    w_sh     = {i_hi, i_lo} >> {i_off, 3'b000};
    case (i_f3)
      F3_LB:   o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_LH:   o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_LBU:  o_rdata = {24'd0, w_sh[7:0]};
      F3_LHU:  o_rdata = {16'd0, w_sh[15:0]};
      default: o_rdata = w_sh[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller in front of a word-addressed memory.
//   req_*  : one byte-addressed load/store per request (req_ready only in IDLE)
//   resp_* : registered one-cycle response, no back-pressure
//   dm_*   : word address, byte write enables, steered write data, comb read data
// Build option LSU_MISALIGN_EN: when defined, word-crossing accesses are split
// into two memory cycles; otherwise misaligned accesses return resp_err.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_wea,
  output logic [31:0]   dm_din,
  input  logic [31:0]   dm_dout
);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;

  logic        w_idle;
  logic        w_bad;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [31:0] w_lo, w_hi, w_din, w_rdata;
  logic [3:0]  w_wea_lo, w_wea_hi;
  logic        w_unused_addr;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle;
  // in IDLE the aligner decodes the incoming request so the first memory
  // cycle's enables/data can be registered on the accepting edge
  assign w_f3  = w_idle ? req_funct3    : r_f3;
  assign w_off = w_idle ? req_addr[1:0] : r_off;
  assign w_unused_addr = |req_addr[31:AW+2];

`ifdef LSU_MISALIGN_EN
  logic [31:0] r_lo;
  logic        r_cross;
  logic        w_cross;
  assign w_cross = |w_wea_hi;
  assign w_lo    = (r_state == S_ACC1) ? r_lo : dm_dout;
  // hi only matters on the edge that ends ACC1, where dm_dout is word+1
  assign w_hi    = dm_dout;
  assign w_bad   = f3_illegal(req_we, req_funct3);
`else
  logic w_unused_hi;
  assign w_unused_hi = |w_wea_hi;
  assign w_lo  = dm_dout;
  assign w_hi  = '0;
  assign w_bad = f3_illegal(req_we, req_funct3) | misaligned(req_funct3[1:0], req_addr[1:0]);
`endif

  lsu_align u_align (
    .i_f3     (w_f3),
    .i_off    (w_off),
    .i_wdata  (req_wdata),
    .i_lo     (w_lo),
    .i_hi     (w_hi),
    .o_wea_lo (w_wea_lo),
    .o_wea_hi (w_wea_hi),
    .o_din    (w_din),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_f3       <= '0;
      r_off      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      dm_addr    <= '0;
      dm_wea     <= '0;
      dm_din     <= '0;
`ifdef LSU_MISALIGN_EN
      r_lo       <= '0;
      r_cross    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we  <= req_we;
            r_f3  <= req_funct3;
            r_off <= req_addr[1:0];
            if (w_bad) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              r_state <= S_ACC0;
              dm_addr <= req_addr[AW+1:2];
              dm_wea  <= req_we ? w_wea_lo : 4'b0000;
              dm_din  <= w_din;
`ifdef LSU_MISALIGN_EN
              r_cross <= w_cross;
`endif
            end
          end
        end
        S_ACC0: begin
`ifdef LSU_MISALIGN_EN
          if (r_cross) begin
            r_lo    <= dm_dout;
            dm_addr <= dm_addr + 1'b1;  // wraps modulo 2^AW
            dm_wea  <= r_we ? w_wea_hi : 4'b0000;
            r_state <= S_ACC1;
          end else
`endif
          begin
            dm_wea     <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= r_we ? 32'd0 : w_rdata;
            r_state    <= S_RESP;
          end
        end
`ifdef LSU_MISALIGN_EN
        S_ACC1: begin
          dm_wea     <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= r_we ? 32'd0 : w_rdata;
          r_state    <= S_RESP;
        end
`endif
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          r_state    <= S_IDLE;
        end
        default: begin
          dm_wea  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  localparam int AW = 10;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] dm_addr;
  logic [3:0]    dm_wea;
  logic [31:0]   dm_din;
  logic [31:0]   dm_dout;

  lsu_ctrl #(.AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_wea(dm_wea), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // memory seen by the DUT
  logic [31:0] mem [0:1023];
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    logic [31:0] nw;
    if (|dm_wea) begin
      nw = mem[dm_addr];
      for (int i = 0; i < 4; i++)
        if (dm_wea[i]) nw[8*i +: 8] = dm_din[8*i +: 8];
      mem[dm_addr] <= nw;
    end
  end

  // reference: flat byte memory, 4 KiB wrapping
  logic [7:0] refm [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cur_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit ill;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
          (we && (f3 == 3'b100 || f3 == 3'b101));
    if (ill) return 1'b1;
    if (!MIS && (a % nbytes(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 0;
    n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = refm[(a + i) & 32'hFFF];
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) refm[(a + i) & 32'hFFF] = wd[8*i +: 8];
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) refm[4*w + i] = v[8*i +: 8];
  endtask

  // Drives one request; returns at the negedge of cycle 1 (first cycle after acceptance).
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit lit, input logic [31:0] lit_rd,
                       input bit lit_err, input string nm);
    int guard;
    bit e;
    int n, lat;
    logic [31:0] rd;
    exp_t x;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: req_ready timeout got 0 expected 1", nm);
      return;
    end
    e  = model_err(we, f3, a);
    n  = nbytes(f3);
    rd = 0;
    if (!e && !we) rd = model_load(f3, a);
    if (!e && we)  model_store(a, n, wd);
    lat = e ? 1 : ((int'(a[1:0]) + n > 4) ? 3 : 2);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    cur_wr = we && !e;
    x.rdata = lit ? lit_rd : rd;
    x.err   = lit ? lit_err : e;
    x.cyc   = cyc + lat;
    x.name  = nm;
    q.push_back(x);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(req_ready && q.size() == 0) && guard < 100) begin @(negedge clk); guard++; end
    if (!(req_ready && q.size() == 0)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: idle timeout, pending %0d expected 0", nm, q.size());
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (!cur_wr || req_ready) chk("wea_idle_or_load", {28'd0, dm_wea}, 32'd0);
      if (resp_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got resp_valid 1 expected 0");
        end else begin
          exp_t x;
          x = q.pop_front();
          chk({x.name, " rdata"}, resp_rdata, x.rdata);
          chk({x.name, " err"}, {31'd0, resp_err}, {31'd0, x.err});
          chk({x.name, " cycle"}, cyc, x.cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] tmp, a, pre;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) refm[i] = 8'd0;
    preload(5, 32'h8899AABB);
    preload(6, 32'h11223344);

    repeat (2) @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst dm_wea", {28'd0, dm_wea}, 32'd0);
    chk("rst dm_addr", {22'd0, dm_addr}, 32'd0);
    chk("rst dm_din", dm_din, 32'd0);
    rstn = 1'b1;

    // directed
    issue(0, 3'b010, 32'h14, 0, 1, 32'h8899AABB, 0, "lw14");
    chk("lw14 addr", {22'd0, dm_addr}, 32'd5);
    issue(0, 3'b000, 32'h17, 0, 1, 32'hFFFFFF88, 0, "lb17");
    issue(0, 3'b100, 32'h17, 0, 1, 32'h00000088, 0, "lbu17");
    issue(0, 3'b001, 32'h16, 0, 1, 32'hFFFF8899, 0, "lh16");
    if (MIS) begin
      issue(0, 3'b010, 32'h17, 0, 1, 32'h22334488, 0, "lw17");
      chk("lw17 acc0 addr", {22'd0, dm_addr}, 32'd5);
      @(negedge clk);
      chk("lw17 acc1 addr", {22'd0, dm_addr}, 32'd6);
    end else begin
      issue(0, 3'b010, 32'h17, 0, 1, 32'h0, 1, "lw17");
    end
    issue(1, 3'b001, 32'h16, 32'h0000CAFE, 1, 32'h0, 0, "sh16");
    chk("sh16 wea", {28'd0, dm_wea}, 32'h0000000C);
    chk("sh16 addr", {22'd0, dm_addr}, 32'd5);
    wait_idle("sh16");
    chk("sh16 word5", mem[5], 32'hCAFEAABB);
    issue(1, 3'b011, 32'h14, 32'hFFFFFFFF, 1, 32'h0, 1, "st011");
    chk("st011 wea", {28'd0, dm_wea}, 32'd0);
    wait_idle("st011");
    chk("st011 word5", mem[5], 32'hCAFEAABB);
    if (MIS) begin
      issue(1, 3'b010, 32'hFFF, 32'hDDCCBBAA, 1, 32'h0, 0, "swfff");
      chk("swfff acc0 addr", {22'd0, dm_addr}, 32'h3FF);
      chk("swfff acc0 wea", {28'd0, dm_wea}, 32'h8);
      @(negedge clk);
      chk("swfff acc1 addr", {22'd0, dm_addr}, 32'h0);
      chk("swfff acc1 wea", {28'd0, dm_wea}, 32'h7);
      wait_idle("swfff");
      chk("swfff word3ff", mem[1023], 32'hAA000000);
      chk("swfff word0", mem[0], 32'h00DDCCBB);
    end else begin
      issue(1, 3'b010, 32'hFFF, 32'hDDCCBBAA, 1, 32'h0, 1, "swfff");
      wait_idle("swfff");
      chk("swfff word3ff", mem[1023], 32'h0);
    end

    // randomized against the byte-level model
    for (int k = 0; k < 400; k++) begin
      tmp = $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'hFF8 + $urandom_range(0, 7);
      else a = $urandom_range(0, 63);
      a = (tmp & 32'hFFFF_F000) | a;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(), 0, 0, 0, "rnd");
    end
    wait_idle("rnd");

    // reset in the middle of a store
    cur_wr = 1'b1;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h5A6B7C8D; req_valid = 1'b1;
    req_addr = MIS ? 32'h2E : 32'h2C;
    pre = mem[12];
    tmp = mem[11];
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid acc0 addr", {22'd0, dm_addr}, 32'd11);
    if (MIS) begin
      chk("rstmid acc0 wea", {28'd0, dm_wea}, 32'hC);
      @(negedge clk);
      chk("rstmid acc1 wea", {28'd0, dm_wea}, 32'h3);
      model_store(32'h2E, 2, 32'h5A6B7C8D);
    end else begin
      chk("rstmid acc0 wea", {28'd0, dm_wea}, 32'hF);
    end
    #2 rstn = 1'b0;
    #1;
    chk("rstmid wea drop", {28'd0, dm_wea}, 32'd0);
    chk("rstmid ready", {31'd0, req_ready}, 32'd1);
    cur_wr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rstmid word+1", mem[12], pre);
    chk("rstmid ready after", {31'd0, req_ready}, 32'd1);
    if (!MIS) chk("rstmid word", mem[11], tmp);

    // final memory image vs model
    for (int w = 0; w < 1024; w++)
      chk($sformatf("mem[%0d]", w), mem[w],
          {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
